switch_debounce3: RTL and testbench
===================================

Name: switch_debounce3

Overview:
- Three-channel switch conditioner that sits directly upstream of the three-switch lamp controller.
- Takes raw, asynchronous, bouncy slide-switch levels from the board.
- Synchronises each one into the clk domain, then debounces it with a per-channel stability counter.
- Presents clean levels that drive the controller's S1/S2/S3 inputs.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive clk cycles a synchronised level must differ from the current stable value before it is accepted; 10 ms at 100 MHz; legal range 1 .. 2^CNT_W-1.
- CNT_W, 20, width of each per-channel stability counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low; sampled on the rising clk edge.
- sw_raw  in  3  raw switch levels, asynchronous to clk; bit0 maps to S1, bit1 to S2, bit2 to S3.
- sw_stable  out  3  debounced levels; registered; bit0 feeds S1, bit1 feeds S2, bit2 feeds S3.
- sw_change  out  1  one-cycle pulse on the cycle after any sw_stable bit updates.

Behaviour:
- Reset (rst_n==0 at a clk edge): sync_a, sync_b, sw_stable, every counter and sw_change go to 0. Reset mid-count discards the count.
- Synchroniser: two flops per channel. sync_a <= sw_raw, then sync_b <= sync_a. Only sync_b is used downstream.
- Channels are fully independent. Each channel i does the following every edge:
  - sync_b[i] == sw_stable[i]: cnt[i] <= 0.
  - sync_b[i] != sw_stable[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - sync_b[i] != sw_stable[i] and cnt[i] == DEBOUNCE_CYCLES-1: sw_stable[i] <= sync_b[i], cnt[i] <= 0.
- Latency:
  - Let E0 be the first edge at which sync_a samples the new level (input held clean).
  - sw_stable changes at edge E0+DEBOUNCE_CYCLES+1.
  - Example: with DEBOUNCE_CYCLES=4, the change appears at E5.
- Glitch rejection: a level held in sync_b for fewer than DEBOUNCE_CYCLES consecutive cycles never reaches sw_stable. The counter restarts from 0 whenever sync_b returns to the stable value.
- A bounce during counting resets that channel's count only; the other channels are unaffected.
- sw_change:
  - Registered; high for exactly one cycle, the edge after any sw_stable bit updates.
  - Several channels updating on the same edge give one single pulse.
  - Updates on consecutive edges give back-to-back pulses.
- DEBOUNCE_CYCLES==1: the accept condition holds on the first mismatch cycle, so latency is 2 edges and there is no filtering beyond the synchroniser.
- The counter never wraps: it is bounded by the accept condition at DEBOUNCE_CYCLES-1.
- No combinational path from sw_raw to any output.

Optional Feature:
- Macro: SWITCH_DEBOUNCE3_EDGE_EN.
- Defined:
  - Adds ports sw_rise (out, 3) and sw_fall (out, 3).
  - sw_rise[i] pulses for one cycle, aligned with sw_change, when sw_stable[i] went 0->1.
  - sw_fall[i] pulses likewise when sw_stable[i] went 1->0.
  - Both reset to 0.
- Undefined: the ports and their registers are absent. All other behaviour is identical.

Test Plan (bench uses DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset: hold rst_n=0 for 3 edges with sw_raw=3'b111 -> sw_stable=3'b000, sw_change=0 throughout. Release -> sw_stable=3'b111 at the 5th edge after the first post-reset sample, with sw_change=1 on the following cycle only.
- Clean change: sw_raw 3'b000->3'b001 at E0 -> sw_stable[0]=1 at E5; sw_change pulses once at E6; bits 1,2 stay 0.
- Glitch: sw_raw[1] high for 3 cycles, then low -> sw_stable stays 3'b000 and sw_change never asserts. Then a bounce train 1,0,1,1,1,1 -> sw_stable[1] rises only after 4 consecutive high sync_b cycles.
- Simultaneous: sw_raw 3'b000->3'b110 on the same edge -> sw_stable=3'b110 at E5, single one-cycle sw_change. Next, sw_raw[2] 1->0 two cycles later -> a second separate pulse.
- Reset mid-count: sw_raw[0]=1, assert rst_n=0 when cnt[0]==2 -> after release the count restarts from 0 and sw_stable[0] rises 5 edges after release sampling.
- With SWITCH_DEBOUNCE3_EDGE_EN: 3'b000->3'b101->3'b001 -> sw_rise=3'b101 for one cycle, then sw_fall=3'b100 for one cycle, each aligned with sw_change.

Source files
------------

// File: rtl/switch_debounce3.sv
// Three-channel switch synchroniser + debouncer feeding the lamp controller's S1/S2/S3.
// Optional edge outputs (sw_rise/sw_fall) are built when SWITCH_DEBOUNCE3_EDGE_EN is defined.

module switch_debounce3_lane #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sync_b,
   output logic stable
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // The counter is bounded by the accept compare, so it never wraps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (sync_b == stable) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         stable <= sync_b;
         cnt    <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

module switch_debounce3 #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] sw_raw,
   output logic [2:0] sw_stable,
`ifdef SWITCH_DEBOUNCE3_EDGE_EN
   output logic [2:0] sw_rise,
   output logic [2:0] sw_fall,
`endif
   output logic       sw_change
);
   localparam int NUM_LANES = 3;

   logic [NUM_LANES-1:0] sync_a, sync_b, stable_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= sw_raw;
         sync_b <= sync_a;
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      switch_debounce3_lane #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .sync_b (sync_b[g]),
         .stable (sw_stable[g])
      );
   end

   // stable_q lags sw_stable by one edge, so the diff lands a cycle after the update.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stable_q  <= '0;
         sw_change <= 1'b0;
      end else begin
         stable_q  <= sw_stable;
         sw_change <= |(sw_stable ^ stable_q);
      end
   end

`ifdef SWITCH_DEBOUNCE3_EDGE_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sw_rise <= '0;
         sw_fall <= '0;
      end else begin
         sw_rise <= sw_stable & ~stable_q;
         sw_fall <= ~sw_stable & stable_q;
      end
   end
`endif
endmodule

// File: tb/tb_switch_debounce3.sv
// Randomised + directed bench for switch_debounce3 against a sliding-window reference model.
// Edge outputs are checked too when SWITCH_DEBOUNCE3_EDGE_EN is defined.

module tb_switch_debounce3;
   localparam int D = 4;
   localparam int W = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] sw_raw = 3'b000;
   logic [2:0] sw_stable;
   logic       sw_change;
`ifdef SWITCH_DEBOUNCE3_EDGE_EN
   logic [2:0] sw_rise, sw_fall;
`endif

   switch_debounce3 #(.DEBOUNCE_CYCLES(D), .CNT_W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw_raw    (sw_raw),
      .sw_stable (sw_stable),
`ifdef SWITCH_DEBOUNCE3_EDGE_EN
      .sw_rise   (sw_rise),
      .sw_fall   (sw_fall),
`endif
      .sw_change (sw_change)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference: a channel flips when its last D synchronised samples since reset
   // all disagree with its current stable level.
   logic [2:0] m_a = '0, m_b = '0, m_stab = '0, m_pend = '0;
   logic [2:0] m_rise = '0, m_fall = '0;
   logic       m_chg = 1'b0;
   logic [2:0] hq[$];

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic [2:0] raw, input logic rstv);
      logic [2:0] flips;
      bit all_diff;
      if (!rstv) begin
         m_a = '0; m_b = '0; m_stab = '0; m_pend = '0;
         m_chg = 1'b0; m_rise = '0; m_fall = '0;
         hq.delete();
         return;
      end
      m_chg  = |m_pend;
      m_rise = m_pend & m_stab;
      m_fall = m_pend & ~m_stab;
      hq.push_back(m_b);
      if (hq.size() > D) void'(hq.pop_front());
      flips = '0;
      for (int i = 0; i < 3; i++) begin
         all_diff = (hq.size() == D);
         foreach (hq[k]) if (hq[k][i] == m_stab[i]) all_diff = 0;
         flips[i] = all_diff;
      end
      m_stab = m_stab ^ flips;
      m_pend = flips;
      m_b = m_a;
      m_a = raw;
   endtask

   task automatic step(input logic [2:0] raw, input logic rstv);
      sw_raw = raw;
      rst_n  = rstv;
      @(posedge clk);
      model_edge(raw, rstv);
      @(negedge clk);
      chk("stable", 8'(sw_stable), 8'(m_stab));
      chk("change", 8'(sw_change), 8'(m_chg));
`ifdef SWITCH_DEBOUNCE3_EDGE_EN
      chk("rise", 8'(sw_rise), 8'(m_rise));
      chk("fall", 8'(sw_fall), 8'(m_fall));
`endif
   endtask

   task automatic run(input logic [2:0] raw, input logic rstv, input int n);
      repeat (n) step(raw, rstv);
   endtask

   initial begin
      // Reset held with switches high, then release.
      run(3'b111, 1'b0, 3);
      chk("rst_stable", 8'(sw_stable), 8'h0);
      chk("rst_change", 8'(sw_change), 8'h0);
      run(3'b111, 1'b1, 5);
      chk("rel_pre_e5", 8'(sw_stable), 8'h0);
      step(3'b111, 1'b1);
      chk("rel_e5", 8'(sw_stable), 8'h7);
      chk("rel_e5_chg", 8'(sw_change), 8'h0);
      step(3'b111, 1'b1);
      chk("rel_e6_chg", 8'(sw_change), 8'h1);
      step(3'b111, 1'b1);
      chk("rel_e7_chg", 8'(sw_change), 8'h0);

      // Clean single-channel change.
      run(3'b000, 1'b1, 8);
      run(3'b001, 1'b1, 5);
      chk("clean_e4", 8'(sw_stable), 8'h0);
      step(3'b001, 1'b1);
      chk("clean_e5", 8'(sw_stable), 8'h1);
      step(3'b001, 1'b1);
      chk("clean_e6_chg", 8'(sw_change), 8'h1);

      // Short glitch rejected, then bounce train accepted after 4 solid highs.
      run(3'b000, 1'b1, 8);
      run(3'b010, 1'b1, 3);
      run(3'b000, 1'b1, 6);
      chk("glitch", 8'(sw_stable), 8'h0);
      step(3'b010, 1'b1);
      step(3'b000, 1'b1);
      run(3'b010, 1'b1, 4);
      chk("bounce_early", 8'(sw_stable), 8'h0);
      run(3'b010, 1'b1, 2);
      chk("bounce_acc", 8'(sw_stable), 8'h2);

      // Two channels together give one pulse; a later change gives another.
      run(3'b000, 1'b1, 8);
      run(3'b110, 1'b1, 6);
      chk("simul_e5", 8'(sw_stable), 8'h6);
      step(3'b110, 1'b1);
      chk("simul_chg", 8'(sw_change), 8'h1);
      run(3'b010, 1'b1, 6);
      chk("second_e5", 8'(sw_stable), 8'h2);
      step(3'b010, 1'b1);
      chk("second_chg", 8'(sw_change), 8'h1);

      // Reset mid-count discards progress.
      run(3'b000, 1'b1, 8);
      run(3'b001, 1'b1, 4);
      step(3'b001, 1'b0);
      run(3'b001, 1'b1, 5);
      chk("midrst_pre", 8'(sw_stable), 8'h0);
      step(3'b001, 1'b1);
      chk("midrst_acc", 8'(sw_stable), 8'h1);

`ifdef SWITCH_DEBOUNCE3_EDGE_EN
      run(3'b000, 1'b1, 8);
      run(3'b101, 1'b1, 7);
      chk("edge_rise", 8'(sw_rise), 8'h5);
      chk("edge_rise_chg", 8'(sw_change), 8'h1);
      run(3'b001, 1'b1, 7);
      chk("edge_fall", 8'(sw_fall), 8'h4);
      chk("edge_fall_chg", 8'(sw_change), 8'h1);
`endif

      // Random holds of 1..6 cycles mix glitches and accepted changes.
      repeat (150) begin
         logic [2:0] v;
         v = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 49) == 0) step(v, 1'b0);
         run(v, 1'b1, int'($urandom_range(1, 6)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
